rsa_decrypt: RTL

Downstream consumer of the RSA encryption datapath. Accepts a 16-bit ciphertext word, computes plaintext = c^D mod N by left-to-right square-and-multiply over a fixed private exponent, and returns the 8-bit plaintext through a valid/ready handshake. With default parameters (N = 3233, D = 2753) it inverts the encryptor's e = 17 transform; a bench can close the loop `m -> encrypt -> decrypt -> m`.

---
 rtl/rsa_pkg.sv | 24 ++
 rtl/rsa_modmul.sv | 36 +++
 rtl/rsa_decrypt.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: constants shared by the RSA encrypt/decrypt pair.
//   N, E, D  : RSA key (N = 61*53, e = 17, d = 2753)
//   ACC_W    : accumulator / reduced-ciphertext width
//   EXP_W    : number of private-exponent bits scanned
//   state_t  : decryptor FSM states
package rsa_pkg;

  localparam int N     = 3233;
  localparam int E     = 17;
  localparam int D     = 2753;
  localparam int ACC_W = 12;
  localparam int EXP_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    SQ_MUL,
    SQ_MOD,
    CM_MUL,
    CM_MOD,
    DONE
  } state_t;

endpackage

// File: rtl/rsa_modmul.sv
// rsa_modmul: two-cycle modular multiplier, r = a*b mod N.
//   clk, rst : clock, async active-high reset
//   mul_en   : capture the full-width product a*b this cycle (MUL phase)
//   a, b     : ACC_W-bit operands
//   r        : reduced result of the captured product, valid in the cycle
//              after mul_en (MOD phase); the caller registers it
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int MOD_N = rsa_pkg::N,
  parameter int W     = rsa_pkg::ACC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mul_en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r
);

  localparam logic [2*W-1:0] N_P = (2*W)'(MOD_N);

  logic [2*W-1:0] prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod <= '0;
    end else if (mul_en) begin
      prod <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end
  end

  // Operands are already < N, so the remainder always fits in W bits.
  assign r = W'(prod % N_P);

endmodule

// File: rtl/rsa_decrypt.sv
// rsa_decrypt: plaintext = c^D mod N by left-to-right square-and-multiply.
//   clk, rst          : clock, async active-high reset
//   in_data/in_valid  : 16-bit ciphertext, accepted only in IDLE (in_ready)
//   out_data          : plaintext, result[7:0]
//   out_overflow      : result > 255
//   out_valid/out_ready : result held in DONE until accepted
//   busy              : any state other than IDLE
//
// state  | meaning
// IDLE   | waiting for ciphertext
// REDUCE | c_reg = c mod N, acc = 1, idx = EXP_W-1
// SQ_MUL | prod = acc*acc
// SQ_MOD | acc = prod mod N, branch on D[idx]
// CM_MUL | prod = acc*c_reg
// CM_MOD | acc = prod mod N, advance idx
// DONE   | result presented until out_ready
module rsa_decrypt
  import rsa_pkg::*;
#(
  parameter int N     = rsa_pkg::N,
  parameter int D     = rsa_pkg::D,
  parameter int EXP_W = rsa_pkg::EXP_W,
  parameter int ACC_W = rsa_pkg::ACC_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam int                 IDX_W  = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [EXP_W-1:0]   D_BITS = EXP_W'(D);
  localparam logic [15:0]        C_N    = 16'(N);

  state_t             state, state_nxt;
  logic [15:0]        c_reg;
  logic [ACC_W-1:0]   acc;
  logic [IDX_W-1:0]   idx;
  logic               mul_en;
  logic               sel_c;
  logic [ACC_W-1:0]   mm_b;
  logic [ACC_W-1:0]   mm_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_en    = 1'b0;
    sel_c     = 1'b0;
    case (state)
      IDLE:   if (in_valid) state_nxt = REDUCE;
      REDUCE: state_nxt = SQ_MUL;
      SQ_MUL: begin
        mul_en    = 1'b1;
        state_nxt = SQ_MOD;
      end
      SQ_MOD: begin
        if (D_BITS[idx])   state_nxt = CM_MUL;
        else if (idx == 0) state_nxt = DONE;
        else               state_nxt = SQ_MUL;
      end
      CM_MUL: begin
        mul_en    = 1'b1;
        sel_c     = 1'b1;
        state_nxt = CM_MOD;
      end
      CM_MOD: state_nxt = (idx == 0) ? DONE : SQ_MUL;
      DONE:   if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_reg <= '0;
      acc   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) c_reg <= in_data;
        REDUCE: begin
          c_reg <= c_reg % C_N;
          acc   <= ACC_W'(1);
          idx   <= IDX_W'(EXP_W - 1);
        end
        // idx only advances once the bit is fully handled: after the square
        // when the bit is 0, after the multiply when it is 1.
        SQ_MOD: begin
          acc <= mm_r;
          if (!D_BITS[idx] && idx != 0) idx <= idx - 1'b1;
        end
        CM_MOD: begin
          acc <= mm_r;
          if (idx != 0) idx <= idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mm_b = sel_c ? c_reg[ACC_W-1:0] : acc;

  rsa_modmul #(
    .MOD_N(N),
    .W    (ACC_W)
  ) u_modmul (
    .clk   (clk),
    .rst   (rst),
    .mul_en(mul_en),
    .a     (acc),
    .b     (mm_b),
    .r     (mm_r)
  );

  assign in_ready     = (state == IDLE);
  assign busy         = (state != IDLE);
  assign out_valid    = (state == DONE);
  assign out_data     = (state == DONE) ? acc[7:0] : 8'd0;
  assign out_overflow = (state == DONE) && (acc > ACC_W'(255));

endmodule
